// File: rtl/store_monitor.sv
// store_monitor: passive observer of the data-memory write bus.
// Every store is timestamped with a free-running cycle counter and queued in
// a show-ahead FIFO that a host drains through a valid/ready port. A sticky
// match flag records the first store of WATCH_DATA to WATCH_ADDR.
module store_monitor #(
  parameter int          DEPTH      = 8,
  parameter int          CYCW       = 16,
  parameter logic [31:0] WATCH_ADDR = 32'd84,
  parameter logic [31:0] WATCH_DATA = 32'h96
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       memwrite,
  input  logic [31:0]                dataadr,
  input  logic [31:0]                writedata,
  input  logic                       pop_ready,
  output logic                       pop_valid,
  output logic [31:0]                pop_addr,
  output logic [31:0]                pop_data,
  output logic [CYCW-1:0]            pop_cycle,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       match,
  output logic [CYCW-1:0]            match_cycle
);

  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH+1);

  // Entry storage holds data only; occupancy and pointers decide validity,
  // so the arrays need no reset.
  logic [31:0]     addr_mem [DEPTH];
  logic [31:0]     data_mem [DEPTH];
  logic [CYCW-1:0] cyc_mem  [DEPTH];

  logic [CYCW-1:0] cycle;
  logic [PTRW-1:0] wr_ptr;
  logic [PTRW-1:0] rd_ptr;

  logic push_req;
  logic full;
  logic pop_fire;
  logic push_fire;
  logic match_hit;

  // Only a clean 1 on the strobe counts as a store; X or Z never pushes.
  assign push_req  = (memwrite === 1'b1);
  assign full      = (count == CNTW'(DEPTH));
  assign pop_valid = (count != '0);
  assign pop_fire  = pop_valid && pop_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_fire = push_req && (!full || pop_fire);
  assign match_hit = push_req && (dataadr == WATCH_ADDR) && (writedata == WATCH_DATA);

  // Show-ahead head; forced to zero while empty so stale storage never leaks.
  assign pop_addr  = pop_valid ? addr_mem[rd_ptr] : '0;
  assign pop_data  = pop_valid ? data_mem[rd_ptr] : '0;
  assign pop_cycle = pop_valid ? cyc_mem[rd_ptr]  : '0;

  // Capture stage: store the bus contents with the current timestamp.
  always_ff @(posedge clk) begin
    if (push_fire && !reset) begin
      addr_mem[wr_ptr] <= dataadr;
      data_mem[wr_ptr] <= writedata;
      cyc_mem[wr_ptr]  <= cycle;
    end
  end

  // Control: cycle counter, pointers, occupancy and sticky flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overflow    <= 1'b0;
      match       <= 1'b0;
      match_cycle <= '0;
    end else begin
      cycle <= cycle + CYCW'(1);
      if (push_fire) wr_ptr <= wr_ptr + PTRW'(1);
      if (pop_fire)  rd_ptr <= rd_ptr + PTRW'(1);
      case ({push_fire, pop_fire})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
      if (push_req && full && !pop_fire) overflow <= 1'b1;
      // Only the first match is timestamped; a dropped store still matches.
      if (match_hit && !match) begin
        match       <= 1'b1;
        match_cycle <= cycle;
      end
    end
  end

endmodule

// File: tb/tb_store_monitor.sv
// Scoreboard bench for store_monitor: stimulus queues expected entries,
// a negedge monitor compares every accepted head entry in order.
module tb_store_monitor;

  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite;
  logic [31:0] dataadr;
  logic [31:0] writedata;
  logic        pop_ready;
  logic        pop_valid;
  logic [31:0] pop_addr;
  logic [31:0] pop_data;
  logic [15:0] pop_cycle;
  logic [3:0]  count;
  logic        overflow;
  logic        match;
  logic [15:0] match_cycle;

  store_monitor #(.DEPTH(8), .CYCW(16), .WATCH_ADDR(32'd84), .WATCH_DATA(32'h96)) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .pop_ready(pop_ready), .pop_valid(pop_valid),
    .pop_addr(pop_addr), .pop_data(pop_data), .pop_cycle(pop_cycle),
    .count(count), .overflow(overflow), .match(match), .match_cycle(match_cycle)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [15:0] c;
  } ent_t;

  ent_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  logic [15:0] tb_cyc;

  // Reference cycle counter: value seen by the DUT at the upcoming edge.
  always @(posedge clk) begin
    if (reset) tb_cyc <= '0;
    else       tb_cyc <= tb_cyc + 16'd1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a pop will happen at the next posedge; compare the head now.
  always @(negedge clk) begin
    if (!reset && pop_valid && pop_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_entry", {32'd0, pop_data}, 64'hDEAD_BEEF_DEAD_BEEF);
      end else begin
        ent_t e;
        e = exp_q.pop_front();
        check("pop_addr",  {32'd0, pop_addr},  {32'd0, e.a});
        check("pop_data",  {32'd0, pop_data},  {32'd0, e.d});
        check("pop_cycle", {48'd0, pop_cycle}, {48'd0, e.c});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input bit keep);
    ent_t e;
    memwrite  = 1'b1;
    dataadr   = a;
    writedata = d;
    if (keep) begin
      e.a = a; e.d = d; e.c = tb_cyc;
      exp_q.push_back(e);
    end
    tick();
    memwrite = 1'b0;
  endtask

  task automatic do_reset(input int n, input logic mw);
    reset    = 1'b1;
    memwrite = mw;
    exp_q.delete();
    repeat (n) tick();
    reset    = 1'b0;
    memwrite = 1'b0;
  endtask

  task automatic drain(input string name);
    int guard = 0;
    pop_ready = 1'b1;
    while (exp_q.size() != 0 && guard < 40) begin
      tick();
      guard++;
    end
    if (exp_q.size() != 0) check({name, "_timeout"}, 64'(exp_q.size()), 64'd0);
    pop_ready = 1'b0;
    check({name, "_count_after_drain"}, {60'd0, count}, 64'd0);
  endtask

  initial begin
    reset = 1'b1; memwrite = 1'b0; dataadr = '0; writedata = '0; pop_ready = 1'b0;

    // 1: reset held two cycles with memwrite high
    dataadr = 32'd84; writedata = 32'h96;
    do_reset(2, 1'b1);
    check("rst_count",     {60'd0, count},     64'd0);
    check("rst_pop_valid", {63'd0, pop_valid}, 64'd0);
    check("rst_match",     {63'd0, match},     64'd0);
    check("rst_overflow",  {63'd0, overflow},  64'd0);
    check("rst_pop_addr",  {32'd0, pop_addr},  64'd0);

    // 2: single matching store at cycle 5
    repeat (5) tick();
    store(32'd84, 32'h96, 1'b1);
    check("t2_pop_valid",   {63'd0, pop_valid},   64'd1);
    check("t2_pop_addr",    {32'd0, pop_addr},    64'd84);
    check("t2_pop_data",    {32'd0, pop_data},    64'h96);
    check("t2_pop_cycle",   {48'd0, pop_cycle},   64'd5);
    check("t2_match",       {63'd0, match},       64'd1);
    check("t2_match_cycle", {48'd0, match_cycle}, 64'd5);
    tick();
    check("t2_pop_hold",    {32'd0, pop_data},    64'h96);
    drain("t2");

    // 3: nine stores into an 8-deep FIFO, no pops
    for (int i = 0; i < 9; i++) store(32'(4*i), 32'(i), i < 8);
    check("t3_count",    {60'd0, count},    64'd8);
    check("t3_overflow", {63'd0, overflow}, 64'd1);
    drain("t3");
    check("t3_match_kept", {48'd0, match_cycle}, 64'd5);

    // 4: full FIFO with simultaneous push and pop
    do_reset(1, 1'b0);
    for (int i = 0; i < 8; i++) store(32'h100 + 32'(4*i), 32'h10 + 32'(i), 1'b1);
    check("t4_full_count", {60'd0, count}, 64'd8);
    pop_ready = 1'b1;
    store(32'h200, 32'hAA, 1'b1);
    pop_ready = 1'b0;
    check("t4_count",    {60'd0, count},    64'd8);
    check("t4_overflow", {63'd0, overflow}, 64'd0);
    drain("t4");

    // empty with pop_ready held: no underflow
    pop_ready = 1'b1;
    repeat (3) tick();
    pop_ready = 1'b0;
    check("empty_count",     {60'd0, count},     64'd0);
    check("empty_pop_valid", {63'd0, pop_valid}, 64'd0);

    // 5: near misses on the watch pair
    do_reset(1, 1'b0);
    store(32'd80, 32'h96, 1'b1);
    store(32'd84, 32'h95, 1'b1);
    tick();
    check("t5_match", {63'd0, match}, 64'd0);
    check("t5_count", {60'd0, count}, 64'd2);
    drain("t5");

    // 6: mid-stream reset with a store in the reset cycle
    for (int i = 0; i < 3; i++) store(32'h300 + 32'(4*i), 32'h30 + 32'(i), 1'b1);
    check("t6_pre_count", {60'd0, count}, 64'd3);
    dataadr = 32'h400; writedata = 32'h40;
    do_reset(1, 1'b1);
    check("t6_count",     {60'd0, count},     64'd0);
    check("t6_pop_valid", {63'd0, pop_valid}, 64'd0);
    store(32'h500, 32'h50, 1'b1);
    check("t6_restart_cycle", {48'd0, pop_cycle}, 64'd0);
    drain("t6");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
